mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage. Consumes the EX/MEM pipeline register outputs and runs loads and stores on a request/acknowledge data-memory port.
- Produces registered write-back fields for the MEM/WB register.
- Stalls upstream stages while an access is outstanding, and aborts on misalignment or memory timeout.

Parameters:
TIMEOUT_CYCLES, 16, WAIT-state cycles without dmem_ack_i before the access is aborted (min 1)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
pc_next4_i  input  32  PC+4 of instruction in stage
ex_res_i  input  64  ALU result / effective address
rr_data2_i  input  64  store data
rd_i  input  5  destination register
regwrite_i  input  1  instruction writes rd
memread_i  input  1  load
memwrite_i  input  1  store
memtoreg_i  input  1  rd gets load data
jump_i  input  1  rd gets PC+4
size_i  input  2  0=byte 1=half 2=word 3=double
unsigned_i  input  1  zero-extend loads
dmem_req_o  output  1  access request, held until ack/abort
dmem_we_o  output  1  write enable
dmem_addr_o  output  64  {ex_res[63:3],3'b000}
dmem_wdata_o  output  64  lane-aligned store data
dmem_be_o  output  8  byte enables
dmem_ack_i  input  1  access done; rdata valid same cycle
dmem_rdata_i  input  64  read doubleword
stall_o  output  1  hold PC, IF/ID, ID/EX, EX/MEM
wb_data_o  output  64  write-back data
rd_o  output  5  write-back register
regwrite_o  output  1  write-back enable
valid_o  output  1  one-cycle pulse per retired instruction
misalign_o  output  1  one-cycle exception pulse
timeout_o  output  1  one-cycle exception pulse

Behaviour:
- Reset: state IDLE, counter 0. Every registered output is 0, including dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, wb_data_o, rd_o, regwrite_o, valid_o, misalign_o and timeout_o.
- Reset mid-WAIT drops dmem_req_o immediately, with no acknowledge required. A late ack in IDLE is ignored.
- access = memread_i | memwrite_i. If both are set, it is treated as a load.
- aligned: size 0 always; size 1 needs addr[0]=0; size 2 needs addr[1:0]=0; size 3 needs addr[2:0]=0.
- stall_o is combinational: (IDLE & access & aligned) | (WAIT & !dmem_ack_i & counter != TIMEOUT_CYCLES-1).
- IDLE, no access, next edge:
  - wb_data_o = jump_i ? zero-extended pc_next4_i : ex_res_i.
  - rd_o and regwrite_o pass through.
  - valid_o = regwrite_i. Bubbles produce valid_o=0.
  - Latency is 1 cycle.
- IDLE, misaligned access, next edge: misalign_o=1, valid_o=1, regwrite_o=0, no request, no stall.
- IDLE, aligned access, next edge:
  - Go to WAIT and assert dmem_req_o.
  - Latch dmem_we_o=memwrite_i & !memread_i, the address, rd, regwrite, memtoreg and size/unsigned.
  - dmem_be_o = (size mask 1/3/F/FF) << addr[2:0].
  - dmem_wdata_o = rr_data2_i << (8*addr[2:0]).
  - Counter cleared.
- WAIT: request fields held stable. Counter increments each cycle without ack.
- WAIT and dmem_ack_i, next edge: go to IDLE, dmem_req_o=0, valid_o=1, regwrite_o=latched regwrite.
  - Loads: wb_data_o = (rdata >> 8*addr[2:0]) truncated to size, then sign- or zero-extended per unsigned.
  - Stores: wb_data_o = address.
- Ack and counter == TIMEOUT_CYCLES-1 in the same cycle: ack wins.
- WAIT, no ack, counter == TIMEOUT_CYCLES-1, next edge: go to IDLE, dmem_req_o=0, timeout_o=1, valid_o=1, regwrite_o=0. Stall is released in that cycle.
- Throughput is at most one access per 2 cycles. The cycle after ack, IDLE evaluates the next instruction with no gap.
- Size 3 ignores unsigned_i.

Test Plan:
- Reset asserted while in WAIT: dmem_req_o falls without waiting for a clock. After release, all outputs are 0 and ack_i=1 has no effect.
- ALU op: ex_res=0x1234, rd=5, regwrite=1 -> next cycle wb_data_o=0x1234, rd_o=5, valid_o=1, stall_o never set.
- Load byte signed, addr=0x1003, ack after 3 WAIT cycles, rdata=0x00000000_80000000 -> wb_data_o=0xFFFF_FFFF_FFFF_FF80, stall_o high 4 cycles. Repeat with unsigned=1 -> 0x80.
- Store half, addr=0x2006, rr_data2=0xBEEF -> be=0xC0, wdata=0xBEEF_0000_0000_0000, we=1, regwrite_o=0 after ack.
- Load word, addr=0x2002 -> misalign_o pulse, no dmem_req_o, regwrite_o=0.
- TIMEOUT_CYCLES=4, no ack -> req held exactly 4 cycles, timeout_o pulse, regwrite_o=0. Repeat with ack on the 4th cycle -> normal completion, no timeout_o.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack data-memory port and
// registers the write-back fields, stalling upstream while an access is pending.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_next4_i,
   input  logic [63:0] ex_res_i,
   input  logic [63:0] rr_data2_i,
   input  logic [4:0]  rd_i,
   input  logic        regwrite_i,
   input  logic        memread_i,
   input  logic        memwrite_i,
   input  logic        memtoreg_i,
   input  logic        jump_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [63:0] dmem_addr_o,
   output logic [63:0] dmem_wdata_o,
   output logic [7:0]  dmem_be_o,
   input  logic        dmem_ack_i,
   input  logic [63:0] dmem_rdata_i,
   output logic        stall_o,
   output logic [63:0] wb_data_o,
   output logic [4:0]  rd_o,
   output logic        regwrite_o,
   output logic        valid_o,
   output logic        misalign_o,
   output logic        timeout_o
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      off_q;
   logic [1:0]      size_q;
   logic            uns_q;
   logic            memtoreg_q;
   logic            regwrite_q;
   logic [4:0]      rd_q;

   logic            access;
   logic            aligned;
   logic [7:0]      size_mask;
   logic [63:0]     rshift;
   logic [63:0]     load_data;

   assign access = memread_i | memwrite_i;

   always_comb begin
      case (size_i)
         2'd0:    begin aligned = 1'b1;             size_mask = 8'h01; end
         2'd1:    begin aligned = ~ex_res_i[0];     size_mask = 8'h03; end
         2'd2:    begin aligned = ~|ex_res_i[1:0];  size_mask = 8'h0F; end
         default: begin aligned = ~|ex_res_i[2:0];  size_mask = 8'hFF; end
      endcase
   end

   assign stall_o = ((state_q == StIdle) & access & aligned) |
                    ((state_q == StWait) & ~dmem_ack_i & (cnt_q != CntLast));

   // Move the addressed lane down to bit 0, then extend to 64 bits.
   always_comb begin
      rshift = dmem_rdata_i >> {off_q, 3'b000};
      case (size_q)
         2'd0:    load_data = {{56{~uns_q & rshift[7]}},  rshift[7:0]};
         2'd1:    load_data = {{48{~uns_q & rshift[15]}}, rshift[15:0]};
         2'd2:    load_data = {{32{~uns_q & rshift[31]}}, rshift[31:0]};
         default: load_data = rshift;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         off_q        <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         memtoreg_q   <= 1'b0;
         regwrite_q   <= 1'b0;
         rd_q         <= '0;
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_wdata_o <= '0;
         dmem_be_o    <= '0;
         wb_data_o    <= '0;
         rd_o         <= '0;
         regwrite_o   <= 1'b0;
         valid_o      <= 1'b0;
         misalign_o   <= 1'b0;
         timeout_o    <= 1'b0;
      end else begin
         valid_o    <= 1'b0;
         misalign_o <= 1'b0;
         timeout_o  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (!access) begin
                  wb_data_o  <= jump_i ? {32'b0, pc_next4_i} : ex_res_i;
                  rd_o       <= rd_i;
                  regwrite_o <= regwrite_i;
                  valid_o    <= regwrite_i;
               end else if (!aligned) begin
                  wb_data_o  <= ex_res_i;
                  rd_o       <= rd_i;
                  regwrite_o <= 1'b0;
                  valid_o    <= 1'b1;
                  misalign_o <= 1'b1;
               end else begin
                  state_q      <= StWait;
                  cnt_q        <= '0;
                  dmem_req_o   <= 1'b1;
                  dmem_we_o    <= memwrite_i & ~memread_i;
                  dmem_addr_o  <= {ex_res_i[63:3], 3'b000};
                  dmem_wdata_o <= rr_data2_i << {ex_res_i[2:0], 3'b000};
                  dmem_be_o    <= size_mask << ex_res_i[2:0];
                  off_q        <= ex_res_i[2:0];
                  size_q       <= size_i;
                  uns_q        <= unsigned_i;
                  memtoreg_q   <= memtoreg_i;
                  regwrite_q   <= regwrite_i;
                  rd_q         <= rd_i;
                  regwrite_o   <= 1'b0;
               end
            end
            StWait: begin
               // An ack in the final counted cycle still completes normally.
               if (dmem_ack_i) begin
                  state_q    <= StIdle;
                  dmem_req_o <= 1'b0;
                  valid_o    <= 1'b1;
                  rd_o       <= rd_q;
                  regwrite_o <= regwrite_q;
                  wb_data_o  <= (!dmem_we_o && memtoreg_q) ? load_data
                                                           : {dmem_addr_o[63:3], off_q};
               end else if (cnt_q == CntLast) begin
                  state_q    <= StIdle;
                  dmem_req_o <= 1'b0;
                  valid_o    <= 1'b1;
                  timeout_o  <= 1'b1;
                  rd_o       <= rd_q;
                  regwrite_o <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases from the test plan
// plus a randomized mix of ALU ops, loads and stores against a behavioural model.
module tb_mem_access_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_next4;
   logic [63:0] ex_res, rr_data2, dmem_rdata;
   logic [4:0]  rd;
   logic        regwrite, memread, memwrite, memtoreg, jump, uns, dmem_ack;
   logic [1:0]  size;
   logic        dmem_req, dmem_we, stall, regwrite_o, valid, misalign, timeout;
   logic [63:0] dmem_addr, dmem_wdata, wb_data;
   logic [7:0]  dmem_be;
   logic [4:0]  rd_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst), .pc_next4_i(pc_next4), .ex_res_i(ex_res),
      .rr_data2_i(rr_data2), .rd_i(rd), .regwrite_i(regwrite), .memread_i(memread),
      .memwrite_i(memwrite), .memtoreg_i(memtoreg), .jump_i(jump), .size_i(size),
      .unsigned_i(uns), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
      .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_be_o(dmem_be),
      .dmem_ack_i(dmem_ack), .dmem_rdata_i(dmem_rdata), .stall_o(stall),
      .wb_data_o(wb_data), .rd_o(rd_o), .regwrite_o(regwrite_o), .valid_o(valid),
      .misalign_o(misalign), .timeout_o(timeout)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      memread = 0; memwrite = 0; memtoreg = 0; jump = 0; regwrite = 0;
   endtask

   // Full memory transaction; lat = WAIT cycles before ack (lat >= TO means never).
   task automatic mem_op(input string nm, input logic rden, input logic wren,
                         input logic [1:0] sz, input logic un, input logic [63:0] addr,
                         input logic [63:0] sdata, input logic [63:0] rdata, input int lat,
                         input logic [4:0] rdn, input logic rw);
      int          nb, off;
      logic        al;
      logic [63:0] mask, exp_wb;
      logic [15:0] be16;
      logic        done;
      nb  = 1 << sz;
      off = int'(addr[2:0]);
      al  = (off % nb) == 0;
      mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
      if (rden) begin
         exp_wb = (rdata >> (8 * off)) & mask;
         if (!un && nb < 8 && exp_wb[8 * nb - 1]) exp_wb = exp_wb | ~mask;
      end else begin
         exp_wb = addr;
      end
      be16 = 16'(((1 << nb) - 1) << off);

      memread = rden; memwrite = wren; memtoreg = rden; jump = 0; size = sz; uns = un;
      ex_res = addr; rr_data2 = sdata; rd = rdn; regwrite = rw;
      #1;
      checks++;
      if (stall !== al) begin
         errors++; $display("FAIL %s idle_stall got %b exp %b", nm, stall, al);
      end
      step();
      bubble();
      if (!al) begin
         checks++;
         if ({misalign, valid, regwrite_o, dmem_req, stall} !== 5'b11000) begin
            errors++;
            $display("FAIL %s misalign got mis=%b v=%b rw=%b req=%b st=%b exp 1 1 0 0 0",
                     nm, misalign, valid, regwrite_o, dmem_req, stall);
         end
         step();
         return;
      end
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== (wren & ~rden) || dmem_addr !== {addr[63:3], 3'b0}
          || dmem_be !== be16[7:0] || dmem_wdata !== (sdata << (8 * off)) || misalign !== 1'b0) begin
         errors++;
         $display("FAIL %s request got req=%b we=%b a=%h be=%h wd=%h exp we=%b a=%h be=%h wd=%h",
                  nm, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wren & ~rden,
                  {addr[63:3], 3'b0}, be16[7:0], sdata << (8 * off));
      end
      done = 0;
      for (int k = 0; k < TO && !done; k++) begin
         dmem_ack = (k == lat);
         dmem_rdata = (k == lat) ? rdata : 64'($urandom);
         #1;
         checks++;
         if (stall !== (k != lat && k != TO - 1) || dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL %s wait%0d got stall=%b req=%b exp stall=%b req=1", nm, k, stall,
                     dmem_req, (k != lat && k != TO - 1));
         end
         step();
         dmem_ack = 0;
         if (k == lat) begin
            done = 1;
            checks++;
            if (valid !== 1'b1 || timeout !== 1'b0 || dmem_req !== 1'b0 || regwrite_o !== rw
                || rd_o !== rdn || wb_data !== exp_wb) begin
               errors++;
               $display("FAIL %s complete got v=%b to=%b req=%b rw=%b rd=%0d wb=%h exp rw=%b rd=%0d wb=%h",
                        nm, valid, timeout, dmem_req, regwrite_o, rd_o, wb_data, rw, rdn, exp_wb);
            end
         end
      end
      if (!done) begin
         checks++;
         if (timeout !== 1'b1 || valid !== 1'b1 || regwrite_o !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout got to=%b v=%b rw=%b req=%b exp 1 1 0 0",
                     nm, timeout, valid, regwrite_o, dmem_req);
         end
      end
   endtask

   task automatic alu_op(input string nm, input logic [63:0] res, input logic [31:0] pc,
                         input logic j, input logic [4:0] rdn, input logic rw);
      logic [63:0] exp_wb;
      exp_wb = j ? {32'b0, pc} : res;
      bubble();
      ex_res = res; pc_next4 = pc; jump = j; rd = rdn; regwrite = rw;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL %s stall got %b exp 0", nm, stall);
      end
      step();
      checks++;
      if (wb_data !== exp_wb || rd_o !== rdn || regwrite_o !== rw || valid !== rw
          || dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL %s alu got wb=%h rd=%0d rw=%b v=%b req=%b exp wb=%h rd=%0d rw=%b v=%b",
                  nm, wb_data, rd_o, regwrite_o, valid, dmem_req, exp_wb, rdn, rw, rw);
      end
   endtask

   task automatic test_reset();
      step();
      step();
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_data, rd_o, regwrite_o,
           valid, misalign, timeout} !== '0) begin
         errors++; $display("FAIL reset outputs got nonzero exp all 0");
      end
      rst = 0;
      step();
   endtask

   task automatic test_reset_mid_wait();
      memread = 1; memwrite = 0; memtoreg = 1; size = 2'd3; uns = 0; ex_res = 64'h4000;
      rd = 5'd9; regwrite = 1;
      step();
      bubble();
      checks++;
      if (dmem_req !== 1'b1) begin
         errors++; $display("FAIL rst_wait req got %b exp 1", dmem_req);
      end
      #2 rst = 1;
      #1;
      checks++;
      if (dmem_req !== 1'b0) begin
         errors++; $display("FAIL rst_wait async_drop got %b exp 0", dmem_req);
      end
      @(posedge clk);
      #1 rst = 0;
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_data, rd_o, regwrite_o,
           valid, misalign, timeout} !== '0) begin
         errors++; $display("FAIL rst_wait outputs got nonzero exp all 0");
      end
      dmem_ack = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (dmem_req !== 1'b0 || valid !== 1'b0 || regwrite_o !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait late_ack got req=%b v=%b rw=%b st=%b exp 0 0 0 0",
                     dmem_req, valid, regwrite_o, stall);
         end
      end
      dmem_ack = 0;
   endtask

   task automatic test_directed();
      alu_op("alu", 64'h1234, 32'h100, 1'b0, 5'd5, 1'b1);
      alu_op("jump", 64'h5555, 32'hFFFF_FFFC, 1'b1, 5'd1, 1'b1);
      alu_op("bubble", 64'h77, 32'h0, 1'b0, 5'd0, 1'b0);
      mem_op("lb_s", 1, 0, 2'd0, 0, 64'h1003, 0, 64'h0000_0000_8000_0000, 3, 5'd7, 1);
      mem_op("lb_u", 1, 0, 2'd0, 1, 64'h1003, 0, 64'h0000_0000_8000_0000, 3, 5'd7, 1);
      mem_op("sh", 0, 1, 2'd1, 0, 64'h2006, 64'hBEEF, 0, 1, 5'd0, 0);
      mem_op("lw_mis", 1, 0, 2'd2, 0, 64'h2002, 0, 0, 0, 5'd3, 1);
      mem_op("timeout", 1, 0, 2'd3, 0, 64'h3000, 0, 64'h1, TO, 5'd4, 1);
      mem_op("ack_last", 1, 0, 2'd3, 1, 64'h3008, 0, 64'h8877_6655_4433_2211, TO - 1, 5'd4, 1);
      mem_op("both_rw", 1, 1, 2'd2, 0, 64'h500C, 64'h1, 64'hF000_0000_0000_0000, 0, 5'd6, 1);
   endtask

   task automatic test_back_to_back();
      mem_op("b2b_ld", 1, 0, 2'd1, 0, 64'h6002, 0, 64'h0000_0000_9ABC_0000, 0, 5'd10, 1);
      alu_op("b2b_alu", 64'hCAFE, 32'h40, 1'b0, 5'd11, 1'b1);
      alu_op("b2b_alu2", 64'hF00D, 32'h44, 1'b0, 5'd12, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         int          kind;
         logic [1:0]  sz;
         logic [63:0] a;
         kind = $urandom_range(0, 3);
         sz = 2'($urandom_range(0, 3));
         a = {32'($urandom), 32'($urandom)};
         if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
         if (kind == 0) begin
            alu_op("rnd_alu", a, 32'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
         end else begin
            logic rdn, wrn;
            rdn = (kind != 2);
            wrn = (kind != 1);
            mem_op("rnd_mem", rdn, wrn, sz, 1'($urandom), a,
                   {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                   int'($urandom_range(0, TO)), 5'($urandom), 1'($urandom));
         end
      end
   endtask

   initial begin
      bubble();
      pc_next4 = 0; ex_res = 0; rr_data2 = 0; rd = 0; size = 0; uns = 0;
      dmem_ack = 0; dmem_rdata = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
